// File: rtl/lu_pkg.sv
// Shared types and constants for the LU working-matrix store and its engine.
package lu_pkg;

    localparam int unsigned LU_SIZE = 16;
    localparam int unsigned FP_W    = 64;
    localparam int unsigned ELEM_W  = 2 * FP_W;

    localparam logic [FP_W-1:0] FP_ONE = 64'h3ff0000000000000;

    typedef struct packed {
        logic [FP_W-1:0] im;
        logic [FP_W-1:0] re;
    } cplx_t;

    typedef cplx_t [LU_SIZE-1:0] row_t;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } store_state_t;

endpackage

// File: rtl/lu_row_regfile.sv
// SIZE-row register array: one sync write port, one registered read port with
// write-through bypass, and one asynchronous read port for draining.
module lu_row_regfile
    import lu_pkg::*;
#(
    parameter int unsigned SIZE = 16,
    parameter int unsigned AW   = $clog2(SIZE)
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   we_i,
    input  logic [AW-1:0]          waddr_i,
    input  logic [SIZE*ELEM_W-1:0] wdata_i,
    input  logic                   re_i,
    input  logic [AW-1:0]          raddr_i,
    output logic [SIZE*ELEM_W-1:0] rdata_o,
    input  logic [AW-1:0]          daddr_i,
    output logic [SIZE*ELEM_W-1:0] ddata_o
);

    localparam int unsigned ROW_W = SIZE * ELEM_W;

    logic [ROW_W-1:0] mem_q [SIZE];
    logic [ROW_W-1:0] rdata_d, rdata_q;

    // Storage is deliberately not reset so contents survive reset and flush.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    always_comb begin
        rdata_d = rdata_q;
        if (re_i) begin
            rdata_d = (we_i && (waddr_i == raddr_i)) ? wdata_i : mem_q[raddr_i];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata_o = rdata_q;
    assign ddata_o = mem_q[daddr_i];

endmodule

// File: rtl/lu_mat_row_store.sv
// Working-matrix store feeding the LU engine: host load, LU read/writeback,
// and ordered drain of the final rows downstream.
module lu_mat_row_store
    import lu_pkg::*;
#(
    parameter int unsigned SIZE = 16,
    parameter int unsigned AW   = $clog2(SIZE)
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [SIZE*ELEM_W-1:0] load_row_i,
    input  logic                   load_valid_i,
    output logic                   load_ready_o,
    output logic                   lu_start_o,
    input  logic [AW-1:0]          rd_addr_i,
    input  logic                   rd_addr_valid_i,
    output logic [SIZE*ELEM_W-1:0] rd_row_o,
    output logic                   rd_row_valid_o,
    output logic [AW-1:0]          rd_row_addr_o,
    input  logic [SIZE*ELEM_W-1:0] wr_row_i,
    input  logic [AW-1:0]          wr_addr_i,
    input  logic                   wr_valid_i,
    output logic                   wr_ready_o,
    input  logic                   drain_i,
    output logic [SIZE*ELEM_W-1:0] out_row_o,
    output logic [AW-1:0]          out_addr_o,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    input  logic                   flush_i,
    output logic                   busy_o
);

    localparam int unsigned ROW_W = SIZE * ELEM_W;
    localparam logic [AW-1:0] LAST_ROW = AW'(SIZE - 1);

    store_state_t     state_d, state_q;
    logic [AW-1:0]    load_ptr_d, load_ptr_q;
    logic [AW-1:0]    drain_ptr_d, drain_ptr_q;
    logic             lu_start_d, lu_start_q;
    logic             rd_valid_d, rd_valid_q;
    logic [AW-1:0]    rd_tag_d, rd_tag_q;
    logic             out_valid_d, out_valid_q;

    logic             mem_we;
    logic [AW-1:0]    mem_waddr;
    logic [ROW_W-1:0] mem_wdata;
    logic             mem_re;
    logic [ROW_W-1:0] drain_row;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= LOAD;
            load_ptr_q  <= '0;
            drain_ptr_q <= '0;
            lu_start_q  <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_tag_q    <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            load_ptr_q  <= load_ptr_d;
            drain_ptr_q <= drain_ptr_d;
            lu_start_q  <= lu_start_d;
            rd_valid_q  <= rd_valid_d;
            rd_tag_q    <= rd_tag_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Next state, pointers and the single shared write port (host load or LU writeback).
    always_comb begin
        state_d     = state_q;
        load_ptr_d  = load_ptr_q;
        drain_ptr_d = drain_ptr_q;
        lu_start_d  = 1'b0;
        rd_valid_d  = 1'b0;
        rd_tag_d    = rd_tag_q;
        out_valid_d = 1'b0;
        mem_we      = 1'b0;
        mem_waddr   = load_ptr_q;
        mem_wdata   = load_row_i;
        mem_re      = 1'b0;

        case (state_q)
            LOAD: begin
                if (load_valid_i) begin
                    mem_we     = 1'b1;
                    load_ptr_d = load_ptr_q + AW'(1);
                    if (load_ptr_q == LAST_ROW) begin
                        state_d    = RUN;
                        lu_start_d = 1'b1;
                    end
                end
            end
            RUN: begin
                mem_re     = rd_addr_valid_i;
                rd_valid_d = rd_addr_valid_i;
                if (rd_addr_valid_i) begin
                    rd_tag_d = rd_addr_i;
                end
                if (wr_valid_i) begin
                    mem_we    = 1'b1;
                    mem_waddr = wr_addr_i;
                    mem_wdata = wr_row_i;
                end
                if (drain_i) begin
                    state_d     = DRAIN;
                    drain_ptr_d = '0;
                    out_valid_d = 1'b1;
                end
            end
            DRAIN: begin
                out_valid_d = 1'b1;
                if (out_ready_i) begin
                    drain_ptr_d = drain_ptr_q + AW'(1);
                    if (drain_ptr_q == LAST_ROW) begin
                        state_d     = LOAD;
                        out_valid_d = 1'b0;
                    end
                end
            end
            default: begin
                state_d = LOAD;
            end
        endcase

        if (flush_i) begin
            state_d     = LOAD;
            load_ptr_d  = '0;
            drain_ptr_d = '0;
            lu_start_d  = 1'b0;
            rd_valid_d  = 1'b0;
            out_valid_d = 1'b0;
            mem_we      = 1'b0;
            mem_re      = 1'b0;
        end
    end

    lu_row_regfile #(
        .SIZE (SIZE),
        .AW   (AW)
    ) u_regfile (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .we_i    (mem_we),
        .waddr_i (mem_waddr),
        .wdata_i (mem_wdata),
        .re_i    (mem_re),
        .raddr_i (rd_addr_i),
        .rdata_o (rd_row_o),
        .daddr_i (drain_ptr_q),
        .ddata_o (drain_row)
    );

    assign load_ready_o   = (state_q == LOAD);
    assign wr_ready_o     = (state_q == RUN);
    assign lu_start_o     = lu_start_q;
    assign rd_row_valid_o = rd_valid_q;
    assign rd_row_addr_o  = rd_tag_q;
    assign out_valid_o    = out_valid_q;
    assign out_addr_o     = drain_ptr_q;
    // Row is forced to zero when not draining so the unreset array never leaks out.
    assign out_row_o      = out_valid_q ? drain_row : '0;
    assign busy_o         = (state_q != LOAD) || (load_ptr_q != '0);

endmodule
